// File: rtl/clint_arbiter.sv
// Two-master round-robin arbiter and sequencer in front of the CLINT register port.
// Each access is captured, range-checked, strobed to the CLINT for one cycle, then acked.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | sample requests, pick a winner, capture its access
// ST_ACCESS | single-cycle wen/ren strobe to the CLINT (suppressed if out of range)
// ST_RESP   | single-cycle ack with rdata/err to the granted master
module clint_arbiter #(
   parameter int               XLEN      = 32,
   parameter logic [XLEN-1:0]  BASE_ADDR = 32'h2000_0000,
   parameter logic [XLEN-1:0]  WIN_SIZE  = 32'h0000_C000
) (
   input  logic            i_clk,
   input  logic            i_rst,

   input  logic            i_m0_req,
   input  logic            i_m0_we,
   input  logic [XLEN-1:0] i_m0_addr,
   input  logic [XLEN-1:0] i_m0_wdata,
   output logic            o_m0_ack,
   output logic            o_m0_err,
   output logic [XLEN-1:0] o_m0_rdata,

   input  logic            i_m1_req,
   input  logic            i_m1_we,
   input  logic [XLEN-1:0] i_m1_addr,
   input  logic [XLEN-1:0] i_m1_wdata,
   output logic            o_m1_ack,
   output logic            o_m1_err,
   output logic [XLEN-1:0] o_m1_rdata,

   output logic            o_s_wen,
   output logic            o_s_ren,
   output logic [XLEN-1:0] o_s_addr,
   output logic [XLEN-1:0] o_s_wrdata,
   input  logic [XLEN-1:0] i_s_rddata,

   output logic            o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t            state;
   logic              last;
   logic              gnt;
   logic              we_q;
   logic              inrange_q;

   logic              gnt_valid;
   logic              gnt_sel;
   logic              sel_we;
   logic [XLEN-1:0]   sel_addr;
   logic [XLEN-1:0]   sel_wdata;
   logic [XLEN-1:0]   sel_offset;
   logic              sel_inrange;
   logic [XLEN-1:0]   resp_data;

   always_comb begin
      gnt_valid = i_m0_req | i_m1_req;
      // On a tie the master that did not win last time goes next.
      if (i_m0_req && i_m1_req) begin
         gnt_sel = ~last;
      end else begin
         gnt_sel = i_m1_req;
      end
      sel_we      = gnt_sel ? i_m1_we    : i_m0_we;
      sel_addr    = gnt_sel ? i_m1_addr  : i_m0_addr;
      sel_wdata   = gnt_sel ? i_m1_wdata : i_m0_wdata;
      sel_offset  = sel_addr - BASE_ADDR;
      sel_inrange = (sel_addr >= BASE_ADDR) && (sel_offset < WIN_SIZE);
      resp_data   = (inrange_q && !we_q) ? i_s_rddata : '0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         last       <= 1'b1;
         gnt        <= 1'b0;
         we_q       <= 1'b0;
         inrange_q  <= 1'b0;
         o_s_wen    <= 1'b0;
         o_s_ren    <= 1'b0;
         o_s_addr   <= '0;
         o_s_wrdata <= '0;
         o_m0_ack   <= 1'b0;
         o_m0_err   <= 1'b0;
         o_m0_rdata <= '0;
         o_m1_ack   <= 1'b0;
         o_m1_err   <= 1'b0;
         o_m1_rdata <= '0;
         o_busy     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (gnt_valid) begin
                  gnt        <= gnt_sel;
                  last       <= gnt_sel;
                  we_q       <= sel_we;
                  inrange_q  <= sel_inrange;
                  o_s_addr   <= sel_addr;
                  o_s_wrdata <= sel_wdata;
                  o_s_wen    <= sel_inrange & sel_we;
                  o_s_ren    <= sel_inrange & ~sel_we;
                  o_busy     <= 1'b1;
                  state      <= ST_ACCESS;
               end
            end

            ST_ACCESS: begin
               o_s_wen <= 1'b0;
               o_s_ren <= 1'b0;
               // Read data is sampled here, while the CLINT still sees the read address.
               if (gnt) begin
                  o_m1_ack   <= 1'b1;
                  o_m1_err   <= ~inrange_q;
                  o_m1_rdata <= resp_data;
               end else begin
                  o_m0_ack   <= 1'b1;
                  o_m0_err   <= ~inrange_q;
                  o_m0_rdata <= resp_data;
               end
               state <= ST_RESP;
            end

            ST_RESP: begin
               o_m0_ack   <= 1'b0;
               o_m0_err   <= 1'b0;
               o_m0_rdata <= '0;
               o_m1_ack   <= 1'b0;
               o_m1_err   <= 1'b0;
               o_m1_rdata <= '0;
               o_busy     <= 1'b0;
               state      <= ST_IDLE;
            end

            default: begin
               o_s_wen <= 1'b0;
               o_s_ren <= 1'b0;
               o_busy  <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clint_arbiter.sv
// Directed bench for clint_arbiter: one task per scenario, inline expected-value checks,
// and a small word-array CLINT model that resets every word to 32'h0000_1234.
module tb_clint_arbiter;

   logic        i_clk;
   logic        i_rst;
   logic        i_m0_req, i_m0_we;
   logic [31:0] i_m0_addr, i_m0_wdata;
   logic        o_m0_ack, o_m0_err;
   logic [31:0] o_m0_rdata;
   logic        i_m1_req, i_m1_we;
   logic [31:0] i_m1_addr, i_m1_wdata;
   logic        o_m1_ack, o_m1_err;
   logic [31:0] o_m1_rdata;
   logic        o_s_wen, o_s_ren;
   logic [31:0] o_s_addr, o_s_wrdata;
   logic [31:0] i_s_rddata;
   logic        o_busy;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [16];

   clint_arbiter dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_m0_req   (i_m0_req),
      .i_m0_we    (i_m0_we),
      .i_m0_addr  (i_m0_addr),
      .i_m0_wdata (i_m0_wdata),
      .o_m0_ack   (o_m0_ack),
      .o_m0_err   (o_m0_err),
      .o_m0_rdata (o_m0_rdata),
      .i_m1_req   (i_m1_req),
      .i_m1_we    (i_m1_we),
      .i_m1_addr  (i_m1_addr),
      .i_m1_wdata (i_m1_wdata),
      .o_m1_ack   (o_m1_ack),
      .o_m1_err   (o_m1_err),
      .o_m1_rdata (o_m1_rdata),
      .o_s_wen    (o_s_wen),
      .o_s_ren    (o_s_ren),
      .o_s_addr   (o_s_addr),
      .o_s_wrdata (o_s_wrdata),
      .i_s_rddata (i_s_rddata),
      .o_busy     (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0000_1234;
      end else if (o_s_wen) begin
         mem[o_s_addr[5:2]] <= o_s_wrdata;
      end
   end
   assign i_s_rddata = mem[o_s_addr[5:2]];

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
      i_m0_req = req; i_m0_we = we; i_m0_addr = addr; i_m0_wdata = wdata;
   endtask

   task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
      i_m1_req = req; i_m1_we = we; i_m1_addr = addr; i_m1_wdata = wdata;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
      drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      checks++;
      if ({o_busy, o_s_wen, o_s_ren, o_m0_ack, o_m0_err, o_m1_ack, o_m1_err} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {o_busy, o_s_wen, o_s_ren, o_m0_ack, o_m0_err, o_m1_ack, o_m1_err});
      end
      checks++;
      if ({o_s_addr, o_s_wrdata, o_m0_rdata, o_m1_rdata} !== 128'h0) begin
         errors++;
         $display("FAIL reset_data: got %h %h %h %h want all 0",
                  o_s_addr, o_s_wrdata, o_m0_rdata, o_m1_rdata);
      end
      i_rst = 1'b0;
      tick();
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_busy: got %b want 0", o_busy);
      end
   endtask

   task automatic test_single_read();
      drive_m0(1'b1, 1'b0, 32'h2000_BFF8, 32'h0);
      tick();
      checks++;
      if ({o_s_ren, o_s_wen, o_busy} !== 3'b101 || o_s_addr !== 32'h2000_BFF8) begin
         errors++;
         $display("FAIL rd_strobe: got ren=%b wen=%b busy=%b addr=%h want 1 0 1 2000bff8",
                  o_s_ren, o_s_wen, o_busy, o_s_addr);
      end
      tick();
      checks++;
      if ({o_m0_ack, o_m0_err, o_m1_ack, o_s_ren} !== 4'b1000 || o_m0_rdata !== 32'h0000_1234) begin
         errors++;
         $display("FAIL rd_ack: got ack0=%b err0=%b ack1=%b ren=%b rdata=%h want 1 0 0 0 00001234",
                  o_m0_ack, o_m0_err, o_m1_ack, o_s_ren, o_m0_rdata);
      end
      drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      checks++;
      if ({o_m0_ack, o_busy, o_m0_rdata} !== 34'h0) begin
         errors++;
         $display("FAIL rd_after: got ack0=%b busy=%b rdata=%h want 0 0 0",
                  o_m0_ack, o_busy, o_m0_rdata);
      end
   endtask

   task automatic test_write_readback();
      drive_m1(1'b1, 1'b1, 32'h2000_4000, 32'hDEAD_BEEF);
      tick();
      checks++;
      if ({o_s_wen, o_s_ren} !== 2'b10 || o_s_addr !== 32'h2000_4000 ||
          o_s_wrdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL wr_strobe: got wen=%b ren=%b addr=%h wdata=%h want 1 0 20004000 deadbeef",
                  o_s_wen, o_s_ren, o_s_addr, o_s_wrdata);
      end
      tick();
      checks++;
      if ({o_m1_ack, o_m1_err, o_m0_ack, o_s_wen} !== 4'b1000 || o_m1_rdata !== 32'h0) begin
         errors++;
         $display("FAIL wr_ack: got ack1=%b err1=%b ack0=%b wen=%b rdata=%h want 1 0 0 0 0",
                  o_m1_ack, o_m1_err, o_m0_ack, o_s_wen, o_m1_rdata);
      end
      drive_m1(1'b1, 1'b0, 32'h2000_4000, 32'h0);
      tick();
      tick();
      checks++;
      if ({o_s_ren, o_s_wen} !== 2'b10 || o_s_addr !== 32'h2000_4000) begin
         errors++;
         $display("FAIL rb_strobe: got ren=%b wen=%b addr=%h want 1 0 20004000",
                  o_s_ren, o_s_wen, o_s_addr);
      end
      tick();
      checks++;
      if ({o_m1_ack, o_m1_err} !== 2'b10 || o_m1_rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL rb_ack: got ack1=%b err1=%b rdata=%h want 1 0 deadbeef",
                  o_m1_ack, o_m1_err, o_m1_rdata);
      end
      drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
   endtask

   task automatic test_out_of_range();
      logic [31:0] addrs [2];
      addrs[0] = 32'h2000_C000;
      addrs[1] = 32'h1FFF_FFFC;
      for (int k = 0; k < 2; k++) begin
         drive_m0(1'b1, k[0], addrs[k], 32'h5555_AAAA);
         tick();
         checks++;
         if ({o_s_wen, o_s_ren, o_busy} !== 3'b001) begin
            errors++;
            $display("FAIL oor_strobe[%0d]: got wen=%b ren=%b busy=%b want 0 0 1",
                     k, o_s_wen, o_s_ren, o_busy);
         end
         tick();
         checks++;
         if ({o_m0_ack, o_m0_err, o_m1_ack} !== 3'b110 || o_m0_rdata !== 32'h0) begin
            errors++;
            $display("FAIL oor_ack[%0d]: got ack0=%b err0=%b ack1=%b rdata=%h want 1 1 0 0",
                     k, o_m0_ack, o_m0_err, o_m1_ack, o_m0_rdata);
         end
         drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
         tick();
      end
   endtask

   task automatic test_contention();
      int          acks0;
      int          acks1;
      logic        exp_m;
      logic [31:0] exp_addr;
      acks0 = 0;
      acks1 = 0;
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      drive_m0(1'b1, 1'b0, 32'h2000_0100, 32'h0);
      drive_m1(1'b1, 1'b0, 32'h2000_0200, 32'h0);
      for (int k = 0; k < 8; k++) begin
         exp_m    = k[0];
         exp_addr = exp_m ? 32'h2000_0200 : 32'h2000_0100;
         tick();
         checks++;
         if (o_s_ren !== 1'b1 || o_s_addr !== exp_addr) begin
            errors++;
            $display("FAIL cont_grant[%0d]: got ren=%b addr=%h want 1 %h",
                     k, o_s_ren, o_s_addr, exp_addr);
         end
         tick();
         checks++;
         if ({o_m0_ack, o_m1_ack} !== {~exp_m, exp_m}) begin
            errors++;
            $display("FAIL cont_ack[%0d]: got ack0=%b ack1=%b want %b %b",
                     k, o_m0_ack, o_m1_ack, ~exp_m, exp_m);
         end
         if (o_m0_ack === 1'b1) acks0++;
         if (o_m1_ack === 1'b1) acks1++;
         if (acks0 == 4) i_m0_req = 1'b0;
         if (acks1 == 4) i_m1_req = 1'b0;
         tick();
         checks++;
         if ({o_m0_ack, o_m1_ack, o_busy} !== 3'b000) begin
            errors++;
            $display("FAIL cont_idle[%0d]: got ack0=%b ack1=%b busy=%b want 0 0 0",
                     k, o_m0_ack, o_m1_ack, o_busy);
         end
      end
      checks++;
      if (acks0 != 4 || acks1 != 4) begin
         errors++;
         $display("FAIL cont_count: got acks0=%0d acks1=%0d want 4 4", acks0, acks1);
      end
      tick();
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL cont_done: got busy=%b want 0", o_busy);
      end
   endtask

   task automatic test_back_to_back();
      drive_m0(1'b1, 1'b0, 32'h2000_0008, 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if ({o_s_ren, o_busy} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_strobe[%0d]: got ren=%b busy=%b want 1 1", k, o_s_ren, o_busy);
         end
         tick();
         checks++;
         if ({o_m0_ack, o_busy, o_s_ren} !== 3'b110 || o_m0_rdata !== 32'h0000_1234) begin
            errors++;
            $display("FAIL b2b_ack[%0d]: got ack0=%b busy=%b ren=%b rdata=%h want 1 1 0 00001234",
                     k, o_m0_ack, o_busy, o_s_ren, o_m0_rdata);
         end
         if (k == 2) i_m0_req = 1'b0;
         tick();
         checks++;
         if ({o_busy, o_s_ren, o_m0_ack} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_idle[%0d]: got busy=%b ren=%b ack0=%b want 0 0 0",
                     k, o_busy, o_s_ren, o_m0_ack);
         end
      end
      tick();
      checks++;
      if ({o_busy, o_s_ren} !== 2'b00) begin
         errors++;
         $display("FAIL b2b_stop: got busy=%b ren=%b want 0 0", o_busy, o_s_ren);
      end
   endtask

   task automatic test_async_reset();
      drive_m1(1'b1, 1'b0, 32'h2000_0010, 32'h0);
      tick();
      checks++;
      if (o_s_ren !== 1'b1) begin
         errors++;
         $display("FAIL arst_pre: got ren=%b want 1", o_s_ren);
      end
      #2;
      i_rst = 1'b1;
      #1;
      checks++;
      if ({o_s_ren, o_s_wen, o_busy} !== 3'b000) begin
         errors++;
         $display("FAIL arst_async: got ren=%b wen=%b busy=%b want 0 0 0", o_s_ren, o_s_wen, o_busy);
      end
      drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      i_rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if ({o_m0_ack, o_m1_ack, o_busy} !== 3'b000) begin
            errors++;
            $display("FAIL arst_noack[%0d]: got ack0=%b ack1=%b busy=%b want 0 0 0",
                     k, o_m0_ack, o_m1_ack, o_busy);
         end
      end
      drive_m0(1'b1, 1'b0, 32'h2000_0020, 32'h0);
      drive_m1(1'b1, 1'b0, 32'h2000_0030, 32'h0);
      tick();
      checks++;
      if (o_s_addr !== 32'h2000_0020) begin
         errors++;
         $display("FAIL arst_tie_grant: got addr=%h want 20000020", o_s_addr);
      end
      tick();
      checks++;
      if ({o_m0_ack, o_m1_ack} !== 2'b10) begin
         errors++;
         $display("FAIL arst_tie_ack: got ack0=%b ack1=%b want 1 0", o_m0_ack, o_m1_ack);
      end
      drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
      drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_readback();
      test_out_of_range();
      test_contention();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clint_arbiter.md
Name: clint_arbiter

Overview:
Two-master arbiter and sequencer in front of the CLINT register port. Master 0 is the hart load/store path; master 1 is the debug/system bus. Each access is registered, range-checked against the CLINT window, issued to the CLINT as a single-cycle wen/ren strobe, and returned to the winning master with a one-cycle ack. Ties are broken round-robin.

Parameters:
XLEN, 32, data and address width.
BASE_ADDR, 32'h2000_0000, base address of the CLINT window.
WIN_SIZE, 32'h0000_C000, CLINT window size in bytes; the decoded range is [BASE_ADDR, BASE_ADDR+WIN_SIZE).

Ports:
i_clk  in  1  clock; all state on the rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_m0_req  in  1  master 0 request (level).
i_m0_we  in  1  master 0 write (1) / read (0).
i_m0_addr  in  XLEN  master 0 byte address.
i_m0_wdata  in  XLEN  master 0 write data.
o_m0_ack  out  1  master 0 completion pulse.
o_m0_err  out  1  master 0 out-of-range flag; valid only with ack.
o_m0_rdata  out  XLEN  master 0 read data; valid only with ack.
i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, o_m1_ack, o_m1_err, o_m1_rdata: same as master 0, for master 1.
o_s_wen  out  1  CLINT write strobe.
o_s_ren  out  1  CLINT read strobe.
o_s_addr  out  XLEN  CLINT address.
o_s_wrdata  out  XLEN  CLINT write data.
i_s_rddata  in  XLEN  CLINT combinational read data.
o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state goes to IDLE and the round-robin pointer `last` to 1, so master 0 wins the first tie. All outputs go to 0, including the captured addr/wdata/rdata registers.
- Reset mid-transaction: the return to IDLE is immediate. Strobes and acks drop asynchronously, the in-flight access is discarded, and no ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled only in this state.
  - If no request, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the master != `last`.
  - On a grant: capture the winner's we/addr/wdata into registers, set `last` to the winner, and compute `inrange` = (addr >= BASE_ADDR) && (addr - BASE_ADDR < WIN_SIZE), with the subtraction unsigned XLEN-bit. Then go to ACCESS.
- ACCESS (exactly one cycle):
  - If inrange: drive o_s_addr/o_s_wrdata from the captured registers and assert exactly one of o_s_wen (we=1) or o_s_ren (we=0). On a read, register i_s_rddata into the response register at the end of the cycle.
  - If not inrange: no strobe, response data = 0, err = 1.
  - Go to RESP.
- RESP (exactly one cycle):
  - Registered ack = 1 only to the granted master, with rdata and err. The non-granted master's ack, err and rdata read 0.
  - Write acks return rdata = 0.
  - Go to IDLE.
- Strobes are 0 in every state except ACCESS. o_s_addr/o_s_wrdata hold their last captured values outside ACCESS.
- Latency: req high in IDLE at cycle t gives the strobe in cycle t+1 and the ack in cycle t+2. Peak throughput is one access per 3 cycles.
- Master rule: hold req, we, addr and wdata stable from req assertion until ack. Req high in the cycle after ack is treated as a new request. Changes to the granted master's inputs after capture are ignored.
- A req raised while the arbiter is busy waits; no request is dropped.
- Fairness: with both masters requesting continuously, grants alternate 0,1,0,1…. A continuous single requester is granted every 3 cycles.
- Address alignment is not checked. Only the range is decoded; the CLINT decodes registers itself.

Test Plan:
- Single read: m0 reads 0x2000_BFF8 while the slave model returns 0x0000_1234 in the ACCESS cycle -> o_s_ren for exactly 1 cycle at t+1 with o_s_addr=0x2000_BFF8; o_m0_ack at t+2 with rdata=0x0000_1234, err=0; o_m1_ack stays 0.
- Write/readback: m1 writes 0xDEAD_BEEF to 0x2000_4000, then reads it back -> o_s_wen for 1 cycle with o_s_wrdata=0xDEAD_BEEF; write ack has rdata=0; the read ack returns the slave value 0xDEAD_BEEF.
- Contention: both masters hold req for 4 transactions each from reset -> grant order 0,1,0,1,…; acks 3 cycles apart; each master sees 4 acks.
- Out of range: m0 accesses 0x2000_C000, then 0x1FFF_FFFC -> no o_s_wen/o_s_ren; ack at t+2 with err=1, rdata=0.
- Async reset: assert i_rst during ACCESS -> o_s_ren/o_s_wen fall without a clock edge; no ack follows; after release, a tie is granted to m0.
- Back-to-back: m0 holds req for 3 reads while m1 is idle -> strobes at cycles t+1, t+4, t+7; o_busy stays high throughout except the IDLE cycles.
